// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode and
// per-class execute/writeback steps for lw, sw, R-type, beq, addi and j.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    logic [2:0] w_funct_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:   r_state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= MEMADR;
                        OP_RTYPE:     r_state <= RTYPEEX;
                        OP_BEQ:       r_state <= BEQEX;
                        OP_ADDI:      r_state <= ADDIEX;
                        OP_J:         r_state <= JEX;
                        default:      r_state <= FETCH;
                    endcase
                end
                MEMADR:  r_state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   r_state <= MEMWB;
                RTYPEEX: r_state <= RTYPEWB;
                ADDIEX:  r_state <= ADDIWB;
                // Terminal states and any unused encoding fall back to FETCH
                default: r_state <= FETCH;
            endcase
        end
    end

    always_comb begin
        case (funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_alu = 3'b010;
        endcase
    end

    always_comb begin
        pcen     = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alucont  = 3'b010;
        case (r_state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcen    = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                alucont = w_funct_alu;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alucont = 3'b110;
                pcsrc   = 2'b01;
                pcen    = zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues the hand-derived control
// word expected each cycle; a negedge monitor pops and compares.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucont;

    mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pcen     (pcen),
        .irwrite  (irwrite),
        .iord     (iord),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .alucont  (alucont)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word order: pcen irwrite iord memwrite regwrite regdst memtoreg
    // alusrca alusrcb[1:0] pcsrc[1:0] alucont[2:0]
    typedef struct {
        logic [14:0] vec;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [14:0] E_FETCH   = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010};
    localparam logic [14:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010};
    localparam logic [14:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010};
    localparam logic [14:0] E_MEMRD   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010};
    localparam logic [14:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b010};
    localparam logic [14:0] E_MEMWR   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010};
    localparam logic [14:0] E_RTYPEWB = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b010};
    localparam logic [14:0] E_ADDIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010};
    localparam logic [14:0] E_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010};
    localparam logic [14:0] E_JEX     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b010};

    function automatic logic [14:0] e_rtypeex(input logic [2:0] alu);
        return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,alu};
    endfunction

    function automatic logic [14:0] e_beqex(input logic z);
        return {z,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110};
    endfunction

    wire [14:0] w_out = {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
                         alusrca, alusrcb, pcsrc, alucont};

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input logic [14:0] e, input string name);
        exp_t x;
        x.vec  = e;
        x.name = name;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (w_out !== x.vec) begin
                errors++;
                $display("FAIL %s got=%b exp=%b (t=%0t)", x.name, w_out, x.vec, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] f;
        logic [2:0] alu;
    } rt_t;

    rt_t rt_tab[6];

    initial begin
        rt_tab[0] = '{6'b101010, 3'b111};
        rt_tab[1] = '{6'b100010, 3'b110};
        rt_tab[2] = '{6'b100101, 3'b001};
        rt_tab[3] = '{6'b111111, 3'b010};
        rt_tab[4] = '{6'b100000, 3'b010};
        rt_tab[5] = '{6'b100100, 3'b000};

        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        step(E_FETCH, "reset_held_fetch");
        reset = 1'b0;

        // lw: five cycles, writeback only in the fifth
        op = 6'b100011;
        step(E_FETCH,  "lw_fetch");
        step(E_DECODE, "lw_decode");
        step(E_MEMADR, "lw_memadr");
        step(E_MEMRD,  "lw_memrd");
        step(E_MEMWB,  "lw_memwb");

        op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = rt_tab[i].f;
            step(E_FETCH,                 "rt_fetch");
            step(E_DECODE,                "rt_decode");
            step(e_rtypeex(rt_tab[i].alu), $sformatf("rt_ex_funct_%b", rt_tab[i].f));
            step(E_RTYPEWB,               "rt_wb");
        end

        op = 6'b000100;
        zero = 1'b1;
        step(E_FETCH,    "beq1_fetch");
        step(E_DECODE,   "beq1_decode");
        step(e_beqex(1), "beq_taken");
        zero = 1'b0;
        step(E_FETCH,    "beq0_fetch");
        step(E_DECODE,   "beq0_decode");
        step(e_beqex(0), "beq_not_taken");

        op = 6'b101011;
        zero = 1'b1;
        step(E_FETCH,  "sw_fetch");
        step(E_DECODE, "sw_decode");
        step(E_MEMADR, "sw_memadr");
        step(E_MEMWR,  "sw_memwr");

        op = 6'b001000;
        step(E_FETCH,  "addi_fetch");
        step(E_DECODE, "addi_decode");
        step(E_ADDIEX, "addi_ex");
        step(E_ADDIWB, "addi_wb");

        op = 6'b000010;
        step(E_FETCH,  "j_fetch");
        step(E_DECODE, "j_decode");
        step(E_JEX,    "j_ex");

        op = 6'b111111;
        step(E_FETCH,  "bad_fetch");
        step(E_DECODE, "bad_decode");

        // Reset lands on the MEMRD->MEMWB edge; MEMWB must not appear
        op = 6'b100011;
        step(E_FETCH,  "lwrst_fetch");
        step(E_DECODE, "lwrst_decode");
        step(E_MEMADR, "lwrst_memadr");
        begin
            exp_t x;
            x.vec  = E_MEMRD;
            x.name = "lwrst_memrd";
            sb.push_back(x);
            @(negedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
        op = 6'b000010;
        step(E_FETCH,  "after_rst_fetch");
        step(E_DECODE, "after_rst_decode");
        step(E_JEX,    "after_rst_jex");
        step(E_FETCH,  "final_fetch");

        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode (instr[31:26]), valid from DECODE onward.
REQ-005 funct  in  6  function field (instr[5:0]), used in RTYPEEX.
REQ-006 zero  in  1  ALU zero flag, sampled combinationally in BEQEX.
REQ-007 pcen  out  1  PC register enable.
REQ-008 irwrite  out  1  instruction register load.
REQ-009 iord  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 memwrite  out  1  data memory write strobe.
REQ-011 regwrite  out  1  register file write enable.
REQ-012 regdst  out  1  write register select: 0=rt, 1=rd.
REQ-013 memtoreg  out  1  writeback select: 0=ALU result register, 1=memory data register.
REQ-014 alusrca  out  1  ALU A select: 0=PC, 1=register A.
REQ-015 alusrcb  out  2  ALU B select: 00=reg B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
REQ-016 pcsrc  out  2  next-PC select: 00=ALU result, 01=ALU result register, 10=jump target.
REQ-017 alucont  out  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.

Function
REQ-018 Control is a Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-019 Transitions: FETCH->DECODE; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX ->FETCH.
REQ-020 DECODE branches on op: 100011 (lw) or 101011 (sw)->MEMADR; 000000->RTYPEEX; 000100 (beq)->BEQEX; 001000 (addi)->ADDIEX; 000010 (j)->JEX; any other op->FETCH (instruction ignored, no state written).
REQ-021 MEMADR->MEMRD if op=100011, else MEMWR.
REQ-022 Any unreachable state encoding SHALL return to FETCH on the next edge.
REQ-023 Per-state outputs (unlisted outputs 0, alucont default 010):
 - FETCH: iord=0, alusrca=0, alusrcb=01, alucont=010, pcsrc=00, irwrite=1, pcen=1.
 - DECODE: alusrca=0, alusrcb=11, alucont=010 (branch target precompute).
 - MEMADR: alusrca=1, alusrcb=10, alucont=010.
 - MEMRD: iord=1.
 - MEMWB: regdst=0, memtoreg=1, regwrite=1.
 - MEMWR: iord=1, memwrite=1.
 - RTYPEEX: alusrca=1, alusrcb=00, alucont from funct.
 - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
 - BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, pcen=zero.
 - ADDIEX: alusrca=1, alusrcb=10, alucont=010.
 - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
 - JEX: pcsrc=10, pcen=1.
REQ-024 Funct decode in RTYPEEX: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010 (ADD), writeback still performed.
REQ-025 pcen is the only output with a combinational input dependency (zero in BEQEX); all other outputs depend on state (and funct in RTYPEEX) only.
REQ-026 Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.
REQ-027 memwrite, regwrite, irwrite and pcen SHALL never be asserted in DECODE or in any state not listed for them above.

Reset
REQ-028 reset high at a rising edge SHALL force state to FETCH regardless of current state, including mid-instruction; no partial writeback state is entered.
REQ-029 While reset is high, outputs SHALL reflect FETCH state decode (pcen=1, irwrite=1); the enclosing datapath gates its own registers by reset.
REQ-030 First cycle after reset deasserts SHALL be FETCH.

Verification
REQ-031 Reset, then op=100011 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-032 op=000000, funct=101010 -> RTYPEEX alucont=111, RTYPEWB regwrite=1 regdst=1; repeat for funct 100010 -> 110, 100101 -> 001, 111111 -> 010.
REQ-033 op=000100 with zero=1 -> pcen=1 pcsrc=01 in BEQEX; with zero=0 -> pcen=0; both return to FETCH next cycle.
REQ-034 op=101011 -> MEMWR cycle 4 with memwrite=1 iord=1, regwrite=0 throughout; op=000010 -> JEX pcen=1 pcsrc=10.
REQ-035 op=111111 -> DECODE then FETCH, no write strobes asserted; reset asserted during MEMRD -> FETCH next edge, MEMWB never entered.
